// File: rtl/vr_7seg.sv
// Hex seven-segment decoder for one common-cathode digit, active-high segments.
// Decode is combinational; the segment lines come straight from flops so they never glitch.
module vr_7seg (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic [3:0] DIG,
  output logic       SEGA,
  output logic       SEGB,
  output logic       SEGC,
  output logic       SEGD,
  output logic       SEGE,
  output logic       SEGF,
  output logic       SEGG
);

  // Pattern bit order is {a,b,c,d,e,f,g}, a in the MSB.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] dig);
    logic [6:0] seg;
    seg = 7'h00;
    case (dig)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [6:0] seg_d;
  logic [6:0] seg_q;

  // Decode stage: blanking wins over the digit code.
  always_comb begin
    seg_d = 7'h00;
    if (EN) seg_d = hex_to_seg(DIG);
  end

  // Output register stage; reset clears the lines without waiting for a clock.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) seg_q <= 7'h00;
    else       seg_q <= seg_d;
  end

  assign SEGA = seg_q[6];
  assign SEGB = seg_q[5];
  assign SEGC = seg_q[4];
  assign SEGD = seg_q[3];
  assign SEGE = seg_q[2];
  assign SEGF = seg_q[1];
  assign SEGG = seg_q[0];

endmodule

// File: tb/tb_vr_7seg.sv
// Bench for vr_7seg: expected segments come from ASCII-art glyphs via a scoreboard queue.
module tb_vr_7seg;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       EN = 1'b0;
  logic [3:0] DIG = 4'h0;
  logic       SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG;

  int n_vec  = 0;
  int n_miss = 0;
  logic [6:0] exp_q[$];
  string glyph [16];

  vr_7seg dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIG(DIG),
    .SEGA(SEGA), .SEGB(SEGB), .SEGC(SEGC), .SEGD(SEGD),
    .SEGE(SEGE), .SEGF(SEGF), .SEGG(SEGG)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] seg_now();
    return {SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG};
  endfunction

  // Glyph is three 3-char rows: " a " / "fgb" / "edc".
  function automatic logic [6:0] art_to_seg(input string s);
    logic [6:0] r;
    r[6] = (s[1] == "_");
    r[5] = (s[5] == "|");
    r[4] = (s[8] == "|");
    r[3] = (s[7] == "_");
    r[2] = (s[6] == "|");
    r[1] = (s[3] == "|");
    r[0] = (s[4] == "_");
    return r;
  endfunction

  function automatic logic [6:0] model(input logic en, input logic [3:0] dig);
    return en ? art_to_seg(glyph[dig]) : 7'h00;
  endfunction

  task automatic chk_seg(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %07b expected %07b", tag, got, exp);
    end
  endtask

  task automatic apply(input string tag, input logic en, input logic [3:0] dig);
    @(negedge CLK);
    EN = en;
    DIG = dig;
    exp_q.push_back(model(en, dig));
    @(posedge CLK);
    #1;
    chk_seg(tag, seg_now(), exp_q.pop_front());
  endtask

  initial begin
    glyph[0]  = " _ | ||_|";
    glyph[1]  = "     |  |";
    glyph[2]  = " _  _||_ ";
    glyph[3]  = " _  _| _|";
    glyph[4]  = "   |_|  |";
    glyph[5]  = " _ |_  _|";
    glyph[6]  = " _ |_ |_|";
    glyph[7]  = " _   |  |";
    glyph[8]  = " _ |_||_|";
    glyph[9]  = " _ |_| _|";
    glyph[10] = " _ |_|| |";
    glyph[11] = "   |_ |_|";
    glyph[12] = " _ |  |_ ";
    glyph[13] = "    _||_|";
    glyph[14] = " _ |_ |_ ";
    glyph[15] = " _ |_ |  ";

    // Reset with EN=1, DIG=8: clears before any clock edge.
    EN = 1'b1;
    DIG = 4'h8;
    #2;
    RESET = 1'b1;
    #1;
    chk_seg("reset_async", seg_now(), 7'h00);
    @(posedge CLK);
    #1;
    chk_seg("reset_hold", seg_now(), 7'h00);
    @(negedge CLK);
    RESET = 1'b0;
    exp_q.push_back(model(1'b1, 4'h8));
    @(posedge CLK);
    #1;
    chk_seg("reset_release", seg_now(), exp_q.pop_front());
    chk_seg("eight_all_lit", seg_now(), 7'h7F);

    // Full sweep, enabled; two hand-written anchors as well.
    for (int i = 0; i < 16; i++) begin
      apply($sformatf("sweep_%0h", i), 1'b1, 4'(i));
      if (i == 1)  chk_seg("dig1_bc", seg_now(), 7'b0110000);
      if (i == 15) chk_seg("digF_aefg", seg_now(), 7'b1000111);
    end

    // Blanking sweep.
    for (int i = 0; i < 16; i++)
      apply($sformatf("blank_%0h", i), 1'b0, 4'(i));

    // EN 0 -> 1 with DIG=2.
    apply("en_off_2", 1'b0, 4'h2);
    apply("en_on_2", 1'b1, 4'h2);

    // Latency: DIG changes just after an edge, outputs hold until the next one.
    apply("lat_1", 1'b1, 4'h1);
    DIG = 4'h7;
    exp_q.push_back(model(1'b1, 4'h7));
    #2;
    chk_seg("lat_hold", seg_now(), model(1'b1, 4'h1));
    @(posedge CLK);
    #1;
    chk_seg("lat_7", seg_now(), exp_q.pop_front());

    // Async reset mid-stream, between edges.
    apply("mid_8", 1'b1, 4'h8);
    #2;
    RESET = 1'b1;
    #1;
    chk_seg("mid_reset_drop", seg_now(), 7'h00);
    @(posedge CLK);
    #1;
    chk_seg("mid_reset_hold", seg_now(), 7'h00);
    @(negedge CLK);
    RESET = 1'b0;
    exp_q.push_back(model(1'b1, 4'h8));
    @(posedge CLK);
    #1;
    chk_seg("mid_release", seg_now(), exp_q.pop_front());

    // Random back-to-back traffic, EN toggling.
    for (int i = 0; i < 24; i++)
      apply($sformatf("rand_%0d", i), 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
